mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory arbiter downstream of the instruction and data caches. Accepts word-granular requests from icache (reads) and dcache (reads, writes, line write-backs and flushes), grants one requester at a time to the shared RAM port, and returns load data and a `wait` handshake to the granted cache. dcache has priority, and a starvation guard forces an icache grant after a bounded run of dcache grants.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: consecutive dcache grants while icache is pending before icache is forced.
- `CNT_W`, default 32: width of performance counters (only with `ARB_PERF_CNT_EN`).

Ports:
- `CLK`  in  1  clock.
- `nRST`  in  1  reset, asynchronous, active-low.
- `iREN`  in  1  icache read request.
- `iaddr`  in  32  icache word address.
- `iload`  out  32  instruction word to icache.
- `iwait`  out  1  high until icache access completes.
- `dREN`  in  1  dcache read request.
- `dWEN`  in  1  dcache write request.
- `daddr`  in  32  dcache word address.
- `dstore`  in  32  dcache write data.
- `dload`  out  32  data word to dcache.
- `dwait`  out  1  high until dcache access completes.
- `ramREN`  out  1  RAM read strobe.
- `ramWEN`  out  1  RAM write strobe.
- `ramaddr`  out  32  RAM address.
- `ramstore`  out  32  RAM write data.
- `ramload`  in  32  RAM read data.
- `ramstate`  in  2  RAM status: FREE, BUSY, ACCESS, ERROR.
- `icount`, `dcount`  out  `CNT_W`  completed icache/dcache accesses (only with `ARB_PERF_CNT_EN`).

## Operation
- States: IDLE, IGNT, DGNT.
- IDLE: no RAM strobes; `iwait`=`dwait`=1. On the clock edge:
  - Any of `dREN`/`dWEN` high and starve count < `STARVE_LIMIT` (or `iREN` low): go to DGNT.
  - Otherwise, if `iREN` is high: go to IGNT.
- DGNT: `ramaddr`=`daddr`. `ramWEN`=`dWEN`. `ramREN`=`dREN & ~dWEN`. `ramstore`=`dstore`.
  - `dWEN` and `dREN` both high is treated as a write.
  - When `ramstate`==ACCESS: `dwait`=0 and `dload`=`ramload` that cycle; next state IDLE.
- IGNT: `ramaddr`=`iaddr`, `ramREN`=1. When `ramstate`==ACCESS: `iwait`=0 and `iload`=`ramload`; next state IDLE.
- Requester deasserts before ACCESS (abort): next state IDLE, no completion. This is legal only on reset or halt.
- ERROR and BUSY: hold the state and keep driving the RAM; the cache's wait stays 1.
- Starve counter (3 bits, saturating at `STARVE_LIMIT`):
  - +1 on each DGNT completion while `iREN`=1.
  - Cleared on an IGNT completion or when `iREN`=0.
- `iload`/`dload` are 0 whenever their wait is 1.

## Timing
- Reset values: state IDLE, starve 0, `iwait`=`dwait`=1, `ramREN`=`ramWEN`=0, `ramaddr`=`ramstore`=0, `iload`=`dload`=0, counters 0.
- Grant latency is 1 cycle: a request sampled in IDLE drives the RAM in the next cycle.
- Minimum access: 2 cycles (IDLE + grant cycle with immediate ACCESS).
- A 2-word dcache line (two requests) takes at least 4 cycles; no other requester is inserted between its words unless the starve limit trips.
- Back-to-back grants always pass through one IDLE cycle.
- Caches hold address and data stable while their wait is high.
- Reset asserted mid-access: immediate return to IDLE, strobes drop asynchronously.

## Configuration
- `ARB_PERF_CNT_EN` defined: `icount`/`dcount` increment on each completion cycle and wrap at 2^`CNT_W`.
- `ARB_PERF_CNT_EN` not defined: the ports and counters are absent. Arbitration behaviour is identical either way.

## Structure
- In `cpu_types_pkg`: `word_t`, `ramstate_t` {FREE=0, BUSY=1, ACCESS=2, ERROR=3}, `arb_state_t` {IDLE, IGNT, DGNT}.
- Sub-module `arb_perf_cnt` holds both counters, instantiated only under `ARB_PERF_CNT_EN`.
- No other hierarchy.

## Test plan
- **icache-only read:**
  - Stimulus: `iREN`=1, `iaddr`=0x40, RAM returns ACCESS with 0xDEADBEEF on its second cycle.
  - Response: `iwait` low exactly one cycle with `iload`=0xDEADBEEF, then IDLE.
- **Simultaneous requests:**
  - Stimulus: `iREN` and `dREN` both 1 in IDLE.
  - Response: dcache granted first; `ramaddr`=`daddr`; icache granted after the dcache completion plus one IDLE cycle.
- **Starvation guard:**
  - Stimulus: dcache issues 6 back-to-back writes while `iREN`=1.
  - Response: after the 4th dcache completion, icache is granted before the 5th write.
- **Write path and error:**
  - Stimulus: `dWEN`=1, `daddr`=0x3100, `dstore`=0x12345678, `ramstate` ERROR for 3 cycles then ACCESS.
  - Response: `ramWEN` held for 4 cycles, `dwait` low only in the final cycle.
- **Reset mid-access:**
  - Stimulus: `nRST` low during DGNT with BUSY.
  - Response: strobes 0 and both waits 1 immediately; a new `iREN` after release is granted normally.
- **Counters (`ARB_PERF_CNT_EN` defined):**
  - Stimulus: 3 icache and 5 dcache completions.
  - Response: `icount`=3, `dcount`=5.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared word, RAM-status and arbiter-state types for the memory subsystem
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3} ramstate_t;
  typedef enum logic [1:0] {IDLE, IGNT, DGNT} arb_state_t;
endpackage

// File: rtl/arb_perf_cnt.sv
// arb_perf_cnt: wrapping completion counters for icache/dcache accesses (ARB_PERF_CNT_EN only)
`ifdef ARB_PERF_CNT_EN
module arb_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             icomp,
  input  logic             dcomp,
  output logic [CNT_W-1:0] icount,
  output logic [CNT_W-1:0] dcount
);
  always_ff @(posedge CLK, negedge nRST)
    if (!nRST) begin
      icount <= '0;
      dcount <= '0;
    end else begin
      icount <= icomp ? icount + 1'b1 : icount;
      dcount <= dcomp ? dcount + 1'b1 : dcount;
    end
endmodule
`endif

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port RAM arbiter for icache/dcache, dcache priority with starvation guard.
// Define ARB_PERF_CNT_EN to add the icount/dcount completion counters.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W = 32
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  word_t       iaddr,
  output word_t       iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  word_t       daddr,
  input  word_t       dstore,
  output word_t       dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output word_t       ramaddr,
  output word_t       ramstore,
  input  word_t       ramload,
  input  logic [1:0]  ramstate
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] icount,
  output logic [CNT_W-1:0] dcount
`endif
);
  if (CNT_W < 1 || STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_param_chk
    $error("mem_arbiter: CNT_W must be >= 1 and STARVE_LIMIT must fit the 3-bit starve counter");
  end
  localparam logic [2:0] LIM = 3'(STARVE_LIMIT);
  arb_state_t state;
  logic [2:0] starve;
  logic d_req, acc, icomp, dcomp;
  assign d_req = dREN | dWEN;
  assign acc = ramstate_t'(ramstate) == ACCESS;
  // a grant whose requester has dropped is an abort, never a completion
  assign icomp = state == IGNT && iREN && acc;
  assign dcomp = state == DGNT && d_req && acc;
  always_comb begin
    ramREN = state == IGNT || (state == DGNT && dREN && !dWEN);
    ramWEN = state == DGNT && dWEN;
    ramaddr = state == IGNT ? iaddr : state == DGNT ? daddr : '0;
    ramstore = state == DGNT ? dstore : '0;
    iwait = !icomp;
    dwait = !dcomp;
    iload = icomp ? ramload : '0;
    dload = dcomp ? ramload : '0;
  end
  always_ff @(posedge CLK, negedge nRST)
    if (!nRST) begin
      state <= IDLE;
      starve <= '0;
    end else begin
      case (state)
        IDLE:    state <= d_req && (starve < LIM || !iREN) ? DGNT : iREN ? IGNT : IDLE;
        IGNT:    state <= !iREN || acc ? IDLE : IGNT;
        DGNT:    state <= !d_req || acc ? IDLE : DGNT;
        default: state <= IDLE;
      endcase
      starve <= !iREN || icomp ? '0 : dcomp && starve < LIM ? starve + 3'd1 : starve;
    end
`ifdef ARB_PERF_CNT_EN
  arb_perf_cnt #(.CNT_W(CNT_W)) u_perf (
    .CLK(CLK), .nRST(nRST), .icomp(icomp), .dcomp(dcomp), .icount(icount), .dcount(dcount)
  );
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus a randomized run against a transaction-level arbiter model
module tb_mem_arbiter;
  import cpu_types_pkg::*;
  localparam int LIM = 4;
  logic CLK = 0, nRST = 0;
  logic iREN = 0, dREN = 0, dWEN = 0;
  logic [31:0] iaddr = 0, daddr = 0, dstore = 0, ramload_d = 0;
  logic [1:0] ramstate = 0;
  logic [31:0] iload, dload, ramaddr, ramstore, ramload;
  logic iwait, dwait, ramREN, ramWEN;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] icount, dcount;
`endif
  logic [31:0] mem [16];
  bit use_mem = 0;
  int checks = 0, failures = 0;

  always #5 CLK = ~CLK;
  assign ramload = use_mem ? (ramstate == 2'd2 ? mem[ramaddr[3:0]] : 32'hBAD0_0BAD) : ramload_d;

  mem_arbiter #(.STARVE_LIMIT(LIM), .CNT_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
`ifdef ARB_PERF_CNT_EN
    , .icount(icount), .dcount(dcount)
`endif
  );

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    nRST = 0; dREN = 1; iREN = 1; daddr = 32'h55; iaddr = 32'h66;
    repeat (2) step();
    #1;
    checks++;
    if ({ramREN, ramWEN, iwait, dwait} !== 4'b0011) begin
      failures++; $display("FAIL reset_ctl: got %b want 0011", {ramREN, ramWEN, iwait, dwait});
    end
    checks++;
    if ({ramaddr, ramstore, iload, dload} !== 128'd0) begin
      failures++; $display("FAIL reset_data: ramaddr=%h ramstore=%h iload=%h dload=%h want all 0", ramaddr, ramstore, iload, dload);
    end
    dREN = 0; iREN = 0;
    @(negedge CLK); nRST = 1;
  endtask

  task automatic test_icache_read;
    step(); iREN = 1; iaddr = 32'h40; ramstate = FREE; #1;
    checks++;
    if ({ramREN, iwait} !== 2'b01) begin
      failures++; $display("FAIL icache_idle: ramREN,iwait got %b want 01", {ramREN, iwait});
    end
    step(); ramstate = ACCESS; ramload_d = 32'hDEADBEEF; #1;
    checks++;
    if ({ramREN, ramWEN, ramaddr} !== {2'b10, 32'h40}) begin
      failures++; $display("FAIL icache_grant: REN=%b WEN=%b addr=%h want 1 0 00000040", ramREN, ramWEN, ramaddr);
    end
    checks++;
    if ({iwait, iload} !== {1'b0, 32'hDEADBEEF}) begin
      failures++; $display("FAIL icache_done: iwait=%b iload=%h want 0 deadbeef", iwait, iload);
    end
    step(); iREN = 0; ramstate = FREE; #1;
    checks++;
    if ({ramREN, iwait, iload} !== {1'b0, 1'b1, 32'h0}) begin
      failures++; $display("FAIL icache_after: REN=%b iwait=%b iload=%h want 0 1 0", ramREN, iwait, iload);
    end
  endtask

  task automatic test_simultaneous;
    step(); iREN = 1; dREN = 1; iaddr = 32'h80; daddr = 32'h200; ramstate = FREE; #1;
    step(); ramstate = ACCESS; ramload_d = 32'h1111_1111; #1;
    checks++;
    if ({ramREN, ramaddr, dwait, dload, iwait} !== {1'b1, 32'h200, 1'b0, 32'h1111_1111, 1'b1}) begin
      failures++; $display("FAIL simul_dfirst: REN=%b addr=%h dwait=%b dload=%h iwait=%b want 1 200 0 11111111 1", ramREN, ramaddr, dwait, dload, iwait);
    end
    step(); dREN = 0; ramstate = FREE; #1;
    checks++;
    if ({ramREN, ramWEN, iwait, dwait} !== 4'b0011) begin
      failures++; $display("FAIL simul_gap: got %b want 0011", {ramREN, ramWEN, iwait, dwait});
    end
    step(); ramstate = ACCESS; ramload_d = 32'h2222_2222; #1;
    checks++;
    if ({ramREN, ramaddr, iwait, iload} !== {1'b1, 32'h80, 1'b0, 32'h2222_2222}) begin
      failures++; $display("FAIL simul_ithen: REN=%b addr=%h iwait=%b iload=%h want 1 80 0 22222222", ramREN, ramaddr, iwait, iload);
    end
    step(); iREN = 0; ramstate = FREE;
  endtask

  task automatic test_starvation;
    int order[$];
    int exp_order[7] = '{0, 0, 0, 0, 1, 0, 0};
    int nd = 0, ni = 0;
    step(); iREN = 1; iaddr = 32'h44; dWEN = 1; daddr = 32'h3000; dstore = 32'h1000;
    for (int cyc = 0; cyc < 60 && (nd < 6 || ni < 1); cyc++) begin
      step();
      ramstate = (ramREN | ramWEN) ? ACCESS : FREE;
      #1;
      if (!dwait) begin
        order.push_back(0); nd++;
        dWEN = nd < 6; daddr = 32'h3000 + nd; dstore = 32'h1000 + nd;
      end
      if (!iwait) begin
        order.push_back(1); ni++; iREN = 0;
      end
    end
    checks++;
    if (order.size() != 7) begin
      failures++; $display("FAIL starve_len: completions got %0d want 7", order.size());
    end
    for (int k = 0; k < order.size() && k < 7; k++) begin
      checks++;
      if (order[k] != exp_order[k]) begin
        failures++; $display("FAIL starve_order[%0d]: got %0d want %0d (0=d,1=i)", k, order[k], exp_order[k]);
      end
    end
    dWEN = 0; iREN = 0; ramstate = FREE;
  endtask

  task automatic test_write_error;
    logic [31:0] exp_load;
    step(); dREN = 1; dWEN = 1; daddr = 32'h3100; dstore = 32'h12345678; ramstate = FREE; #1;
    checks++;
    if (ramWEN !== 1'b0) begin
      failures++; $display("FAIL wr_idle: ramWEN got %b want 0", ramWEN);
    end
    for (int k = 0; k < 4; k++) begin
      step(); ramstate = (k < 3) ? ERROR : ACCESS; ramload_d = 32'h0BADF00D; #1;
      exp_load = (k < 3) ? 32'h0 : 32'h0BADF00D;
      checks++;
      if ({ramREN, ramWEN, ramaddr, ramstore} !== {1'b0, 1'b1, 32'h3100, 32'h12345678}) begin
        failures++; $display("FAIL wr_drive[%0d]: REN=%b WEN=%b addr=%h store=%h want 0 1 3100 12345678", k, ramREN, ramWEN, ramaddr, ramstore);
      end
      checks++;
      if ({dwait, dload} !== {k < 3, exp_load}) begin
        failures++; $display("FAIL wr_wait[%0d]: dwait=%b dload=%h want %b %h", k, dwait, dload, k < 3, exp_load);
      end
    end
    step(); dREN = 0; dWEN = 0; ramstate = FREE; #1;
    checks++;
    if ({ramWEN, dwait, dload} !== {1'b0, 1'b1, 32'h0}) begin
      failures++; $display("FAIL wr_after: WEN=%b dwait=%b dload=%h want 0 1 0", ramWEN, dwait, dload);
    end
  endtask

  task automatic test_reset_mid;
    step(); dREN = 1; daddr = 32'h500; #1;
    step(); ramstate = BUSY; #1;
    checks++;
    if ({ramREN, dwait, ramaddr} !== {1'b1, 1'b1, 32'h500}) begin
      failures++; $display("FAIL rst_busy: REN=%b dwait=%b addr=%h want 1 1 500", ramREN, dwait, ramaddr);
    end
    #1; nRST = 0; #1;
    checks++;
    if ({ramREN, ramWEN, iwait, dwait, ramaddr} !== {4'b0011, 32'h0}) begin
      failures++; $display("FAIL rst_async: REN=%b WEN=%b iwait=%b dwait=%b addr=%h want 0 0 1 1 0", ramREN, ramWEN, iwait, dwait, ramaddr);
    end
    dREN = 0; ramstate = FREE;
    @(negedge CLK); nRST = 1;
    step(); iREN = 1; iaddr = 32'h60; #1;
    step(); ramstate = ACCESS; ramload_d = 32'hCAFEF00D; #1;
    checks++;
    if ({ramREN, ramaddr, iwait, iload} !== {1'b1, 32'h60, 1'b0, 32'hCAFEF00D}) begin
      failures++; $display("FAIL rst_regrant: REN=%b addr=%h iwait=%b iload=%h want 1 60 0 cafef00d", ramREN, ramaddr, iwait, iload);
    end
    step(); iREN = 0; ramstate = FREE;
  endtask

`ifdef ARB_PERF_CNT_EN
  task automatic one_access(input bit is_d);
    step(); iREN = !is_d; dREN = is_d; ramstate = FREE;
    step(); ramstate = ACCESS;
    step(); iREN = 0; dREN = 0; ramstate = FREE;
  endtask

  task automatic test_counters;
    @(negedge CLK); nRST = 0; @(negedge CLK); nRST = 1;
    for (int k = 0; k < 8; k++) one_access(k != 1 && k != 4 && k != 6);
    #1;
    checks++;
    if ({icount, dcount} !== {32'd3, 32'd5}) begin
      failures++; $display("FAIL counters: icount=%0d dcount=%0d want 3 5", icount, dcount);
    end
  endtask
`endif

  task automatic test_random;
    int owner = 0, run = 0, dly = 0;
    bit i_pend = 0, d_pend = 0, d_wr = 0, d_both = 0, ir, acc;
    logic [31:0] i_a = 0, d_a = 0, d_data = 0, exp_load, exp_addr;
    logic [3:0] exp_ctl;
    for (int k = 0; k < 16; k++) mem[k] = $urandom;
    iREN = 0; dREN = 0; dWEN = 0; ramstate = FREE;
    @(negedge CLK); nRST = 0; @(negedge CLK); nRST = 1; use_mem = 1;
    for (int c = 0; c < 600; c++) begin
      step();
      if (!i_pend && $urandom_range(2) == 0) begin
        i_pend = 1; i_a = $urandom;
      end
      if (!d_pend && $urandom_range(2) == 0) begin
        d_pend = 1; d_wr = 1'($urandom_range(1)); d_both = 1'($urandom_range(1));
        d_a = $urandom; d_data = $urandom;
      end
      iREN = i_pend; iaddr = i_a; dWEN = d_pend & d_wr; dREN = d_pend & (!d_wr | d_both);
      daddr = d_a; dstore = d_data;
      ramstate = owner == 0 ? FREE : dly > 0 ? ($urandom_range(1) ? BUSY : ERROR) : ACCESS;
      if (dly > 0) dly--;
      acc = owner != 0 && ramstate == ACCESS;
      exp_addr = owner == 1 ? i_a : d_a;
      exp_load = acc ? mem[exp_addr[3:0]] : 32'h0;
      exp_ctl = owner == 0 ? 4'b0011 : owner == 1 ? {2'b10, !acc, 1'b1} : {!d_wr, d_wr, 1'b1, !acc};
      #1;
      checks++;
      if ({ramREN, ramWEN, iwait, dwait} !== exp_ctl) begin
        failures++; $display("FAIL rnd_ctl cycle %0d: REN,WEN,iwait,dwait got %b want %b", c, {ramREN, ramWEN, iwait, dwait}, exp_ctl);
      end
      if (owner != 0) begin
        checks++;
        if (ramaddr !== exp_addr) begin
          failures++; $display("FAIL rnd_addr cycle %0d: got %h want %h", c, ramaddr, exp_addr);
        end
      end
      if (owner == 2 && d_wr) begin
        checks++;
        if (ramstore !== d_data) begin
          failures++; $display("FAIL rnd_store cycle %0d: got %h want %h", c, ramstore, d_data);
        end
      end
      checks++;
      if ({iload, dload} !== {owner == 1 ? exp_load : 32'h0, owner == 2 ? exp_load : 32'h0}) begin
        failures++; $display("FAIL rnd_load cycle %0d owner %0d: iload=%h dload=%h want load %h", c, owner, iload, dload, exp_load);
      end
      ir = i_pend;
      if (acc && owner == 1) begin
        i_pend = 0; run = 0;
      end else if (acc && owner == 2) begin
        if (d_wr) mem[d_a[3:0]] = d_data;
        d_pend = 0;
        if (ir && run < LIM) run++;
      end
      if (acc) owner = 0;
      else if (owner == 0) begin
        if (d_pend && (run < LIM || !i_pend)) owner = 2;
        else if (i_pend) owner = 1;
        dly = $urandom_range(3);
      end
      if (!ir) run = 0;
    end
    step(); iREN = 0; dREN = 0; dWEN = 0; ramstate = FREE; use_mem = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_icache_read();
    test_simultaneous();
    test_starvation();
    test_write_error();
    test_reset_mid();
`ifdef ARB_PERF_CNT_EN
    test_counters();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
